// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  // Controller states: serving hits, writing back a dirty victim, refilling a block.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Per-set storage for the data cache: valid/dirty control bits plus tag and
// block data. Combinational read of the addressed set, a byte-write port for
// CPU stores and a block-write port for refills. Only the control bits are
// cleared by reset; tag and data contents are don't-care while invalid.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int ARR_TAG_W    = TAG_W,
  parameter int ARR_INDEX_W  = INDEX_W,
  parameter int ARR_OFFSET_W = OFFSET_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ARR_INDEX_W-1:0]        index,
  output logic                          rd_valid,
  output logic                          rd_dirty,
  output logic [ARR_TAG_W-1:0]          rd_tag,
  output logic [(8<<ARR_OFFSET_W)-1:0]  rd_data,
  input  logic                          byte_we,
  input  logic [ARR_OFFSET_W-1:0]       byte_off,
  input  logic [7:0]                    byte_data,
  input  logic                          blk_we,
  input  logic [ARR_TAG_W-1:0]          blk_tag,
  input  logic [(8<<ARR_OFFSET_W)-1:0]  blk_data
);

  localparam int SETS  = 1 << ARR_INDEX_W;
  localparam int BLK_W = 8 << ARR_OFFSET_W;

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [ARR_TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0]     data_q [SETS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // Control bits: refill makes the set valid and clean, a CPU store marks it dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (blk_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage: whole-block refill or a single byte merged in by a store.
  always_ff @(posedge clk) begin
    if (blk_we) begin
      tag_q[index]  <= blk_tag;
      data_q[index] <= blk_data;
    end else if (byte_we) begin
      data_q[index][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller. Hits are served with no
// stall; a miss optionally writes back the dirty victim and then refills the
// block from word-organised memory, holding the CPU with BUSYWAIT meanwhile.
module dcache_controller #(
  parameter int ADDR_W   = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         READ,
  input  logic                         WRITE,
  input  logic [ADDR_W-1:0]            ADDRESS,
  input  logic [7:0]                   WRITEDATA,
  output logic [7:0]                   READDATA,
  output logic                         BUSYWAIT,
  output logic                         MEM_READ,
  output logic                         MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0]   MEM_ADDRESS,
  output logic [(8<<OFFSET_W)-1:0]     MEM_WRITEDATA,
  input  logic [(8<<OFFSET_W)-1:0]     MEM_READDATA,
  input  logic                         MEM_BUSYWAIT
);

  import dcache_pkg::*;

  localparam int TW = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BW = 8 << OFFSET_W;

  state_t              state_q, state_d;
  logic [TW-1:0]       addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_off;
  logic                rd_valid, rd_dirty;
  logic [TW-1:0]       rd_tag;
  logic [BW-1:0]       rd_data;
  logic                hit, req, byte_we, blk_we;

  assign addr_tag   = ADDRESS[ADDR_W-1 -: TW];
  assign addr_index = ADDRESS[OFFSET_W +: INDEX_W];
  assign addr_off   = ADDRESS[OFFSET_W-1:0];

  assign hit      = rd_valid & (rd_tag == addr_tag);
  assign req      = READ | WRITE;
  assign BUSYWAIT = req & ~((state_q == IDLE) & hit);
  // A simultaneous READ and WRITE is handled as a write; the read port still
  // shows the byte as it was before the store lands.
  assign byte_we  = (state_q == IDLE) & hit & WRITE;
  assign READDATA = hit ? rd_data[{addr_off, 3'b000} +: 8] : 8'h00;

  dcache_array #(
    .ARR_TAG_W    (TW),
    .ARR_INDEX_W  (INDEX_W),
    .ARR_OFFSET_W (OFFSET_W)
  ) u_array (
    .clk       (CLK),
    .rst       (RESET),
    .index     (addr_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .byte_we   (byte_we),
    .byte_off  (addr_off),
    .byte_data (WRITEDATA),
    .blk_we    (blk_we),
    .blk_tag   (addr_tag),
    .blk_data  (MEM_READDATA)
  );

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory request outputs, which depend only on the state and
  // on stable set/address contents so they hold steady through WB and FILL.
  always_comb begin
    state_d       = state_q;
    blk_we        = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (rd_valid && rd_dirty) ? WB : FILL;
        end
      end
      WB: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {rd_tag, addr_index};
        MEM_WRITEDATA = rd_data;
        if (!MEM_BUSYWAIT) begin
          state_d = FILL;
        end
      end
      FILL: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
        if (!MEM_BUSYWAIT) begin
          blk_we  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back data cache controller between the CPU datapath and word-organised main memory. It serves the byte READ/WRITE requests decoded for lwd/lwi/swd/swi and stalls the CPU via BUSYWAIT on misses. Misses are resolved by an optional dirty write-back followed by a block refill.

## Interface
- `ADDR_W`, 8: CPU byte address width.
- `INDEX_W`, 3: index bits; 2**INDEX_W sets.
- `OFFSET_W`, 2: byte offset bits; block = 4 bytes = 32 bits.
- `CLK`  in  1  clock; all state changes on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `READ`  in  1  CPU byte read request.
- `WRITE`  in  1  CPU byte write request.
- `ADDRESS`  in  8  byte address: tag [7:5], index [4:2], offset [1:0].
- `WRITEDATA`  in  8  store byte.
- `READDATA`  out  8  load byte.
- `BUSYWAIT`  out  1  CPU stall.
- `MEM_READ`  out  1  block read request.
- `MEM_WRITE`  out  1  block write request.
- `MEM_ADDRESS`  out  6  block address {tag, index}.
- `MEM_WRITEDATA`  out  32  write-back block.
- `MEM_READDATA`  in  32  refill block.
- `MEM_BUSYWAIT`  in  1  memory busy.

## Operation
- Per set: valid, dirty, tag[2:0], data[31:0]. Byte k of a block is data[8k+7:8k].
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- The CPU holds ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT=1.
- FSM states: IDLE, WB (write-back), FILL (refill).
- IDLE:
  - Read hit: READDATA = selected byte (combinational). BUSYWAIT=0.
  - Write hit: at the posedge, the byte is written and dirty is set. BUSYWAIT=0.
  - Miss with victim clean or invalid: go to FILL.
  - Miss with victim valid and dirty: go to WB.
- WB:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=stored block.
  - Completes at the first posedge, after at least one cycle in the state, where MEM_BUSYWAIT=0. Then go to FILL.
- FILL:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5], index}.
  - Completion uses the same rule as WB. On completion: data=MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0, go to IDLE.
  - The request now hits and is served as above. A write therefore sets dirty only after the refill.
- BUSYWAIT = (READ | WRITE) & ~(state==IDLE & hit).
- READ and WRITE both high is illegal. The controller treats it as a write; READDATA still shows the pre-write byte.
- No request pending: the FSM stays in IDLE, and MEM_READ=MEM_WRITE=0.

## Timing
- Reset (asynchronous, at any time including mid-WB or mid-FILL):
  - state=IDLE; all valid and dirty bits cleared.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - BUSYWAIT follows its equation, so it is 0 with no request.
  - Any in-flight memory transaction is abandoned. The tag and data arrays need not be cleared.
- Hit latency: 0 stall cycles.
- Miss latency with N = number of cycles MEM_BUSYWAIT stays high per request:
  - Clean miss: BUSYWAIT high for N+2 cycles.
  - Dirty miss: BUSYWAIT high for 2N+3 cycles.
- Memory request outputs are registered by state and stay constant for the whole of WB or FILL.
- A refill array write and a CPU write never occur on the same edge.

## Structure
- Shared package `dcache_pkg`:
  - state enum {IDLE, WB, FILL}.
  - TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32.
- One sub-module, `dcache_array`:
  - Holds valid, dirty, tag and data storage.
  - Combinational read port; a byte-write port and a block-write port.
  - Asynchronous clear of the valid and dirty bits.
- The FSM, hit logic and BUSYWAIT logic live in `dcache_controller`.

## Test plan
Memory model: N=5 for all scenarios.
- Reset, then READ at 0x00 (cold miss), memory returns 0x44332211:
  - BUSYWAIT high 7 cycles, with MEM_READ=1 and MEM_ADDRESS=0x00 during FILL.
  - Then READDATA=0x11.
  - A following read at 0x03 returns 0x44 with zero stall.
- WRITE 0xAB at 0x01 after that fill:
  - No stall; dirty[0]=1.
  - A following read at 0x01 returns 0xAB.
- Dirty conflict, read at 0x20 (same index, tag 1):
  - WB with MEM_WRITE=1, MEM_ADDRESS=0x00, MEM_WRITEDATA=0x4433AB11.
  - Then FILL with MEM_ADDRESS=0x08.
  - BUSYWAIT high 13 cycles in total.
- Clean conflict, read at 0x40 after a read-only fill of index 0:
  - No WB; BUSYWAIT high 7 cycles.
- RESET pulsed at cycle 3 of FILL:
  - Immediately: MEM_READ=0, state=IDLE, valid=0.
  - Re-issuing the same read misses again.
- Write miss at 0x25 with 0x5A on a clean set:
  - FILL, then the byte is written.
  - Block byte 1 = 0x5A; dirty=1.
